// File: rtl/freq_pkg.sv
// Shared constants and types for the programmable integer clock divider.
package freq_pkg;
  localparam int FREQ_WIDTH       = 8;
  localparam int FREQ_DEFAULT_DIV = 4;
  localparam int FREQ_MIN_DIV     = 2;

  typedef logic [FREQ_WIDTH-1:0] div_t;
endpackage

// File: rtl/freq_div_prog_if.sv
// Control and output bundle of the programmable divider.
// Handshake: a ratio transfers on a clk edge where div_valid && div_ready; div_in must be stable while div_valid is high.
interface freq_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] div_in;
  logic             div_valid;
  logic             div_ready;
  logic             clk_out;
  logic             nclk_out;
  logic             tick;
  logic             err;
  logic [WIDTH-1:0] cur_div;

  modport master (
    output en, div_in, div_valid,
    input  div_ready, clk_out, nclk_out, tick, err, cur_div
  );

  modport slave (
    input  en, div_in, div_valid,
    output div_ready, clk_out, nclk_out, tick, err, cur_div
  );
endinterface

// File: rtl/freq_div_core.sv
// Period counter with wrap detection and registered square-wave / tick outputs.
module freq_div_core
  import freq_pkg::*;
#(
  parameter int WIDTH       = FREQ_WIDTH,
  parameter int DEFAULT_DIV = FREQ_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_cur_div,
  input  logic [WIDTH-1:0] i_next_div,
  output logic             o_wrap,
  output logic             o_clk_out,
  output logic             o_nclk_out,
  output logic             o_tick
);
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_half;
  logic             r_clk_out;
  logic             r_nclk_out;
  logic             r_tick;

  assign o_wrap     = (r_cnt == i_cur_div - WIDTH'(1));
  assign w_cnt_next = o_wrap ? '0 : r_cnt + WIDTH'(1);
  // The high phase uses the ratio that will be in force after this edge.
  assign w_half     = i_next_div >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= WIDTH'(DEFAULT_DIV - 1);
      r_clk_out  <= 1'b0;
      r_nclk_out <= 1'b1;
      r_tick     <= 1'b0;
    end else if (i_en) begin
      r_cnt      <= w_cnt_next;
      r_clk_out  <= (w_cnt_next < w_half);
      r_nclk_out <= !(w_cnt_next < w_half);
      r_tick     <= (w_cnt_next == '0);
    end else begin
      r_tick     <= 1'b0;
    end
  end

  assign o_clk_out  = r_clk_out;
  assign o_nclk_out = r_nclk_out;
  assign o_tick     = r_tick;
endmodule

// File: rtl/freq_div_prog.sv
// Programmable divider top: ratio handshake, pending register, legality check, and core.
module freq_div_prog
  import freq_pkg::*;
#(
  parameter int WIDTH       = FREQ_WIDTH,
  parameter int DEFAULT_DIV = FREQ_DEFAULT_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  freq_div_prog_if.slave    bus
);
  logic [WIDTH-1:0] r_cur_div;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] w_next_div;
  logic             r_ready;
  logic             r_err;
  logic             w_wrap;
  logic             w_offer;
  logic             w_accept;
  logic             w_illegal;
  logic             w_apply;

  assign w_offer    = bus.div_valid && r_ready;
  assign w_accept   = w_offer && (bus.div_in >= WIDTH'(FREQ_MIN_DIV));
  assign w_illegal  = w_offer && (bus.div_in <  WIDTH'(FREQ_MIN_DIV));
  // Not ready means a ratio is pending; it only lands on an enabled wrap.
  assign w_apply    = bus.en && w_wrap && !r_ready;
  assign w_next_div = w_apply ? r_pend : r_cur_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_div <= WIDTH'(DEFAULT_DIV);
      r_pend    <= '0;
      r_ready   <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_illegal;
      if (w_apply) begin
        r_cur_div <= r_pend;
        r_ready   <= 1'b1;
      end else if (w_accept) begin
        r_pend  <= bus.div_in;
        r_ready <= 1'b0;
      end
    end
  end

  freq_div_core #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (bus.en),
    .i_cur_div  (r_cur_div),
    .i_next_div (w_next_div),
    .o_wrap     (w_wrap),
    .o_clk_out  (bus.clk_out),
    .o_nclk_out (bus.nclk_out),
    .o_tick     (bus.tick)
  );

  assign bus.div_ready = r_ready;
  assign bus.err       = r_err;
  assign bus.cur_div   = r_cur_div;
endmodule

// File: tb/tb_freq_div_prog.sv
// Self-checking bench for freq_div_prog: period-level reference model plus directed literal checks.
module tb_freq_div_prog;
  import freq_pkg::*;
  localparam int W   = FREQ_WIDTH;
  localparam int DEF = FREQ_DEFAULT_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_on = 1'b0;
  int   checks = 0;
  int   errors = 0;

  freq_div_prog_if #(.WIDTH(W)) bus ();

  freq_div_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: position within the current output period and ratio in force.
  int m_n     = DEF;
  int m_pos   = DEF - 1;
  int m_pend  = 0;
  bit m_ready = 1'b1;
  bit m_clk   = 1'b0;
  bit m_tick  = 1'b0;
  bit m_err   = 1'b0;
  bit m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = DEF; m_pos = DEF - 1; m_ready = 1'b1;
      m_clk = 1'b0; m_tick = 1'b0; m_err = 1'b0;
    end else begin
      m_acc = bus.div_valid && m_ready && (int'(bus.div_in) >= 2);
      m_err = bus.div_valid && m_ready && (int'(bus.div_in) < 2);
      if (bus.en) begin
        if (m_pos == m_n - 1) begin
          m_pos = 0;
          if (!m_ready) begin
            m_n = m_pend;
            m_ready = 1'b1;
          end
        end else begin
          m_pos = m_pos + 1;
        end
        m_clk  = (m_pos < m_n / 2);
        m_tick = (m_pos == 0);
      end else begin
        m_tick = 1'b0;
      end
      if (m_acc) begin
        m_pend  = int'(bus.div_in);
        m_ready = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Scoreboard compare against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("m_clk_out",  32'(bus.clk_out),   32'(m_clk));
      check("m_nclk_out", 32'(bus.nclk_out),  32'(!m_clk));
      check("m_tick",     32'(bus.tick),      32'(m_tick));
      check("m_err",      32'(bus.err),       32'(m_err));
      check("m_ready",    32'(bus.div_ready), 32'(m_ready));
      check("m_cur_div",  32'(bus.cur_div),   32'(m_n));
    end
  end

  task automatic load(input int d);
    @(posedge clk); #2;
    bus.div_valid = 1'b1;
    bus.div_in    = W'(d);
    @(posedge clk); #2;
    bus.div_valid = 1'b0;
  endtask

  task automatic wait_div(input int d, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (int'(bus.cur_div) == d) break;
    end
    check("apply_timeout", 32'(i < limit), 32'd1);
  endtask

  initial begin
    int hi;
    int r;
    bus.en = 1'b0; bus.div_valid = 1'b0; bus.div_in = '0;
    #1 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    #20 rst_n = 1'b1; bus.en = 1'b1;

    // Default ratio 4: high 2, low 2, tick every 4 edges from edge 1.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("t1_clk",  32'(bus.clk_out), 32'((i % 4) < 2));
      check("t1_tick", 32'(bus.tick),    32'((i % 4) == 0));
    end

    // Illegal ratio: one-cycle err, ratio untouched.
    load(1);
    @(negedge clk);
    check("t3_err",   32'(bus.err),       32'd1);
    check("t3_ready", 32'(bus.div_ready), 32'd1);
    check("t3_div",   32'(bus.cur_div),   32'd4);
    @(negedge clk);
    check("t3_err_clr", 32'(bus.err), 32'd0);

    // Ratio 3: high 1, low 2.
    load(3);
    wait_div(3, 10);
    check("t2_tick0", 32'(bus.tick),    32'd1);
    check("t2_clk0",  32'(bus.clk_out), 32'd1);
    @(negedge clk);
    check("t2_clk1",  32'(bus.clk_out), 32'd0);
    @(negedge clk);
    check("t2_clk2",  32'(bus.clk_out), 32'd0);
    @(negedge clk);
    check("t2_clk3",  32'(bus.clk_out), 32'd1);
    check("t2_tick3", 32'(bus.tick),    32'd1);

    // Pending ratio discarded by an asynchronous reset between edges.
    load(6);
    rst_n = 1'b0;
    #1;
    check("t5_clk",   32'(bus.clk_out),   32'd0);
    check("t5_nclk",  32'(bus.nclk_out),  32'd1);
    check("t5_tick",  32'(bus.tick),      32'd0);
    check("t5_div",   32'(bus.cur_div),   32'd4);
    check("t5_ready", 32'(bus.div_ready), 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_not6", 32'(bus.cur_div), 32'd4);

    // Maximum ratio 255: 127 high, 128 low, tick every 255 edges.
    load(255);
    wait_div(255, 20);
    check("t6_tick0", 32'(bus.tick), 32'd1);
    hi = int'(bus.clk_out);
    for (int i = 1; i < 255; i++) begin
      @(negedge clk);
      hi += int'(bus.clk_out);
    end
    @(negedge clk);
    check("t6_high", 32'(hi), 32'd127);
    check("t6_tick", 32'(bus.tick), 32'd1);
    load(2);
    wait_div(2, 300);
    for (int i = 0; i < 6; i++) begin
      check("t6_toggle", 32'(bus.clk_out), 32'((i % 2) == 0));
      @(negedge clk);
    end

    // Randomized enable, offers and occasional resets against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      rst_n         = ($urandom_range(0, 499) != 0);
      bus.en        = ($urandom_range(0, 9) != 0);
      bus.div_valid = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 9);
      if (r < 2)      bus.div_in = W'($urandom_range(0, 1));
      else if (r < 9) bus.div_in = W'($urandom_range(2, 9));
      else            bus.div_in = W'($urandom_range(10, 255));
    end
    @(posedge clk); #2;
    rst_n = 1'b1; bus.div_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
